pla_top_ctrl: RTL and testbench



---
 rtl/pla_pkg.sv | 24 ++
 rtl/pla_decode.sv | 27 ++
 rtl/pla_top_ctrl.sv | 102 ++++++++++
 tb/tb_pla_top_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pla_pkg.sv
// rtl/pla_pkg.sv - shared opcodes, function codes and enums for the PLA dispatch controller
package pla_pkg;

  localparam logic [5:0] OPC_ACCEL = 6'b111111;

  localparam logic [2:0] FN_FFT = 3'b001;
  localparam logic [2:0] FN_FIR = 3'b011;
  localparam logic [2:0] FN_IIR = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_FFT,
    SEL_FIR,
    SEL_IIR
  } sel_t;

endpackage

// File: rtl/pla_decode.sv
// rtl/pla_decode.sv - combinational accelerator instruction decoder
module pla_decode
  import pla_pkg::*;
(
  input  logic [31:0] instruction,
  output logic        valid,
  output sel_t        sel
);

  // Bits [25:3] carry no meaning for dispatch.
  logic unused_bits;
  assign unused_bits = ^instruction[25:3];

  always_comb begin
    sel = SEL_NONE;
    if (instruction[31:26] == OPC_ACCEL) begin
      case (instruction[2:0])
        FN_FFT:  sel = SEL_FFT;
        FN_FIR:  sel = SEL_FIR;
        FN_IIR:  sel = SEL_IIR;
        default: sel = SEL_NONE;
      endcase
    end
    valid = (sel != SEL_NONE);
  end

endmodule

// File: rtl/pla_top_ctrl.sv
// rtl/pla_top_ctrl.sv - FFT/FIR/IIR dispatch FSM with registered enables and completion flag
module pla_top_ctrl
  import pla_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        fft_read_done,
  input  logic        fft_write_done,
  input  logic        fir_read_done,
  input  logic        fir_write_done,
  input  logic        iir_read_done,
  input  logic        iir_write_done,
  output logic        fft_enable,
  output logic        fir_enable,
  output logic        iir_enable,
  output logic        acc_done
);

  state_t      state;
  sel_t        sel_q;
  logic [31:0] instr_q;

  logic        dec_valid;
  sel_t        dec_sel;
  logic        read_done;
  logic        write_done;

  pla_decode u_decode (
    .instruction (instruction),
    .valid       (dec_valid),
    .sel         (dec_sel)
  );

  // Only the latched unit's done levels are visible, so stale levels elsewhere are ignored.
  always_comb begin
    read_done  = 1'b0;
    write_done = 1'b0;
    case (sel_q)
      SEL_FFT: begin read_done = fft_read_done; write_done = fft_write_done; end
      SEL_FIR: begin read_done = fir_read_done; write_done = fir_write_done; end
      SEL_IIR: begin read_done = iir_read_done; write_done = iir_write_done; end
      default: begin read_done = 1'b0;          write_done = 1'b0;           end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel_q      <= SEL_NONE;
      instr_q    <= 32'd0;
      fft_enable <= 1'b0;
      fir_enable <= 1'b0;
      iir_enable <= 1'b0;
      acc_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fft_enable <= 1'b0;
          fir_enable <= 1'b0;
          iir_enable <= 1'b0;
          acc_done   <= 1'b0;
          if (dec_valid) begin
            sel_q      <= dec_sel;
            instr_q    <= instruction;
            fft_enable <= (dec_sel == SEL_FFT);
            fir_enable <= (dec_sel == SEL_FIR);
            iir_enable <= (dec_sel == SEL_IIR);
            state      <= READ;
          end
        end
        READ: begin
          if (read_done) state <= WRITE;
        end
        WRITE: begin
          if (write_done) begin
            fft_enable <= 1'b0;
            fir_enable <= 1'b0;
            iir_enable <= 1'b0;
            acc_done   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          // Holding the same word keeps us here; it must be removed before a reissue.
          if (instruction != instr_q) begin
            acc_done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          fft_enable <= 1'b0;
          fir_enable <= 1'b0;
          iir_enable <= 1'b0;
          acc_done   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pla_top_ctrl.sv
// tb/tb_pla_top_ctrl.sv - directed-vector bench for pla_top_ctrl
module tb_pla_top_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        fft_read_done, fft_write_done;
  logic        fir_read_done, fir_write_done;
  logic        iir_read_done, iir_write_done;
  logic        fft_enable, fir_enable, iir_enable, acc_done;
  logic [3:0]  outs;

  int vectors;
  int miscompares;

  assign outs = {fft_enable, fir_enable, iir_enable, acc_done};

  pla_top_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .instruction    (instruction),
    .fft_read_done  (fft_read_done),
    .fft_write_done (fft_write_done),
    .fir_read_done  (fir_read_done),
    .fir_write_done (fir_write_done),
    .iir_read_done  (iir_read_done),
    .iir_write_done (iir_write_done),
    .fft_enable     (fft_enable),
    .fir_enable     (fir_enable),
    .iir_enable     (iir_enable),
    .acc_done       (acc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dones();
    fft_read_done = 0; fft_write_done = 0;
    fir_read_done = 0; fir_write_done = 0;
    iir_read_done = 0; iir_write_done = 0;
  endtask

  // outs = {fft_enable, fir_enable, iir_enable, acc_done}
  task automatic test_reset();
    reset = 1; instruction = 32'h0; clear_dones();
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (outs !== 4'b0000) begin
        $display("FAIL reset_cycle%0d outs=%b expected=%b", i, outs, 4'b0000);
        miscompares++;
      end
    end
  endtask

  task automatic test_fft();
    reset = 0; instruction = 32'hFC000001;
    step(); // launch edge
    vectors++;
    if (outs !== 4'b1000) begin
      $display("FAIL fft_launch outs=%b expected=%b", outs, 4'b1000); miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (outs !== 4'b1000) begin
        $display("FAIL fft_read_wait%0d outs=%b expected=%b", i, outs, 4'b1000); miscompares++;
      end
    end
    fft_read_done = 1;
    step(); // launch+4: READ -> WRITE
    vectors++;
    if (outs !== 4'b1000) begin
      $display("FAIL fft_to_write outs=%b expected=%b", outs, 4'b1000); miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (outs !== 4'b1000) begin
        $display("FAIL fft_write_wait%0d outs=%b expected=%b", i, outs, 4'b1000); miscompares++;
      end
    end
    fft_write_done = 1;
    step(); // launch+8: WRITE -> DONE
    vectors++;
    if (outs !== 4'b0001) begin
      $display("FAIL fft_done outs=%b expected=%b", outs, 4'b0001); miscompares++;
    end
    step();
    vectors++;
    if (outs !== 4'b0001) begin
      $display("FAIL fft_done_hold outs=%b expected=%b", outs, 4'b0001); miscompares++;
    end
  endtask

  task automatic test_fir();
    // FFT done levels remain high and must be ignored.
    instruction = 32'hFC000003;
    step();
    vectors++;
    if (outs !== 4'b0000) begin
      $display("FAIL fir_to_idle outs=%b expected=%b", outs, 4'b0000); miscompares++;
    end
    step();
    vectors++;
    if (outs !== 4'b0100) begin
      $display("FAIL fir_launch outs=%b expected=%b", outs, 4'b0100); miscompares++;
    end
    step();
    vectors++;
    if (outs !== 4'b0100) begin
      $display("FAIL fir_read_wait outs=%b expected=%b", outs, 4'b0100); miscompares++;
    end
    fir_read_done = 1;
    step();
    vectors++;
    if (outs !== 4'b0100) begin
      $display("FAIL fir_to_write outs=%b expected=%b", outs, 4'b0100); miscompares++;
    end
    step();
    vectors++;
    if (outs !== 4'b0100) begin
      $display("FAIL fir_write_wait outs=%b expected=%b", outs, 4'b0100); miscompares++;
    end
    fir_write_done = 1;
    step();
    vectors++;
    if (outs !== 4'b0001) begin
      $display("FAIL fir_done outs=%b expected=%b", outs, 4'b0001); miscompares++;
    end
  endtask

  task automatic test_iir();
    instruction = 32'hFC000007;
    step();
    vectors++;
    if (outs !== 4'b0000) begin
      $display("FAIL iir_to_idle outs=%b expected=%b", outs, 4'b0000); miscompares++;
    end
    step();
    vectors++;
    if (outs !== 4'b0010) begin
      $display("FAIL iir_launch outs=%b expected=%b", outs, 4'b0010); miscompares++;
    end
    step();
    vectors++;
    if (outs !== 4'b0010) begin
      $display("FAIL iir_read_wait outs=%b expected=%b", outs, 4'b0010); miscompares++;
    end
    iir_read_done = 1;
    step();
    vectors++;
    if (outs !== 4'b0010) begin
      $display("FAIL iir_to_write outs=%b expected=%b", outs, 4'b0010); miscompares++;
    end
    iir_write_done = 1;
    step();
    vectors++;
    if (outs !== 4'b0001) begin
      $display("FAIL iir_done outs=%b expected=%b", outs, 4'b0001); miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    // Same word must be removed before it can be reissued.
    step();
    vectors++;
    if (outs !== 4'b0001) begin
      $display("FAIL b2b_same_word outs=%b expected=%b", outs, 4'b0001); miscompares++;
    end
    instruction = 32'h0;
    step();
    vectors++;
    if (outs !== 4'b0000) begin
      $display("FAIL b2b_idle outs=%b expected=%b", outs, 4'b0000); miscompares++;
    end
    // Don't-care bits set; IIR done levels already high on entry.
    instruction = 32'hFC0ABCDF;
    step();
    vectors++;
    if (outs !== 4'b0010) begin
      $display("FAIL b2b_launch outs=%b expected=%b", outs, 4'b0010); miscompares++;
    end
    step();
    vectors++;
    if (outs !== 4'b0010) begin
      $display("FAIL b2b_write outs=%b expected=%b", outs, 4'b0010); miscompares++;
    end
    step();
    vectors++;
    if (outs !== 4'b0001) begin
      $display("FAIL b2b_done3 outs=%b expected=%b", outs, 4'b0001); miscompares++;
    end
    instruction = 32'h0;
    step();
    vectors++;
    if (outs !== 4'b0000) begin
      $display("FAIL b2b_release outs=%b expected=%b", outs, 4'b0000); miscompares++;
    end
  endtask

  task automatic test_invalid();
    logic [31:0] bad [2];
    bad[0] = 32'h00000001;
    bad[1] = 32'hFC000005;
    clear_dones();
    for (int k = 0; k < 2; k++) begin
      instruction = bad[k];
      for (int i = 0; i < 4; i++) begin
        fft_read_done = (i == 0); fft_write_done = (i == 1);
        fir_read_done = (i == 1); fir_write_done = (i == 2);
        iir_read_done = (i == 2); iir_write_done = (i == 3);
        step();
        vectors++;
        if (outs !== 4'b0000) begin
          $display("FAIL invalid_%h_%0d outs=%b expected=%b", bad[k], i, outs, 4'b0000); miscompares++;
        end
      end
    end
    clear_dones();
  endtask

  task automatic test_reset_mid();
    instruction = 32'hFC000003;
    step();
    vectors++;
    if (outs !== 4'b0100) begin
      $display("FAIL rmid_launch outs=%b expected=%b", outs, 4'b0100); miscompares++;
    end
    fir_read_done = 1;
    step();
    fir_read_done = 0;
    vectors++;
    if (outs !== 4'b0100) begin
      $display("FAIL rmid_write outs=%b expected=%b", outs, 4'b0100); miscompares++;
    end
    reset = 1;
    fir_write_done = 1; // reset must win over the WRITE -> DONE transition
    step();
    vectors++;
    if (outs !== 4'b0000) begin
      $display("FAIL rmid_reset outs=%b expected=%b", outs, 4'b0000); miscompares++;
    end
    reset = 0;
    fir_write_done = 0;
    step();
    vectors++;
    if (outs !== 4'b0100) begin
      $display("FAIL rmid_relaunch outs=%b expected=%b", outs, 4'b0100); miscompares++;
    end
    fir_read_done = 1;
    step();
    vectors++;
    if (outs !== 4'b0100) begin
      $display("FAIL rmid_rewrite outs=%b expected=%b", outs, 4'b0100); miscompares++;
    end
    fir_write_done = 1;
    step();
    vectors++;
    if (outs !== 4'b0001) begin
      $display("FAIL rmid_done outs=%b expected=%b", outs, 4'b0001); miscompares++;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fft();
    test_fir();
    test_iir();
    test_back_to_back();
    test_invalid();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
